// File: rtl/mc_control_pkg.sv
// mc_control_pkg: shared types and constants for the multicycle MIPS control.
// Holds ALU op codes, state encoding, opcode/funct values, mux selects, ctrl bundle.
package mc_control_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD = 4'd0;
  localparam alu_op_t OP_SUB = 4'd1;
  localparam alu_op_t OP_AND = 4'd2;
  localparam alu_op_t OP_OR  = 4'd3;
  localparam alu_op_t OP_XOR = 4'd4;
  localparam alu_op_t OP_NOR = 4'd5;
  localparam alu_op_t OP_SLT = 4'd6;
  localparam alu_op_t OP_SLL = 4'd7;
  localparam alu_op_t OP_SRL = 4'd8;
  localparam alu_op_t OP_SRA = 4'd9;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEM_ADR = 5'd2,
    S_MEM_RD  = 5'd3,
    S_MEM_WB  = 5'd4,
    S_MEM_WR  = 5'd5,
    S_R_EXEC  = 5'd6,
    S_R_WB    = 5'd7,
    S_I_EXEC  = 5'd8,
    S_I_WB    = 5'd9,
    S_BRANCH  = 5'd10,
    S_JUMP    = 5'd11,
    S_JAL     = 5'd12,
    S_JR      = 5'd13
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG   = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [2:0] SRCB_REG    = 3'd0;
  localparam logic [2:0] SRCB_FOUR   = 3'd1;
  localparam logic [2:0] SRCB_IMM    = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH = 3'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REG    = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  typedef struct packed {
    alu_op_t    alu_control;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       reg_write;
    logic       i_or_d;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       imm_zext;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: instruction fields + mem_ready in, datapath controls out.
// master = controller side, slave = datapath/IR side.
interface mc_control_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int STATE_W    = 5
);
  logic [5:0]            op;
  logic [5:0]            funct;
  logic                  mem_ready;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [1:0]            alu_src_a;
  logic [2:0]            alu_src_b;
  logic [1:0]            pc_src;
  logic [1:0]            reg_dst;
  logic [1:0]            mem_to_reg;
  logic                  pc_write;
  logic                  branch;
  logic                  branch_ne;
  logic                  reg_write;
  logic                  i_or_d;
  logic                  mem_req;
  logic                  mem_write;
  logic                  ir_write;
  logic                  imm_zext;
  logic                  illegal_op;
  logic [STATE_W-1:0]    state_o;

  modport master (
    input  op, funct, mem_ready,
    output alu_control, alu_src_a, alu_src_b,
    output pc_src, reg_dst, mem_to_reg,
    output pc_write, branch, branch_ne,
    output reg_write, i_or_d, mem_req,
    output mem_write, ir_write, imm_zext,
    output illegal_op, state_o
  );

  modport slave (
    output op, funct, mem_ready,
    input  alu_control, alu_src_a, alu_src_b,
    input  pc_src, reg_dst, mem_to_reg,
    input  pc_write, branch, branch_ne,
    input  reg_write, i_or_d, mem_req,
    input  mem_write, ir_write, imm_zext,
    input  illegal_op, state_o
  );
endinterface

// File: rtl/mc_funct_decode.sv
// mc_funct_decode: R-type funct -> ALU op, shift/jr flags, illegal flag.
// Ports: funct_i in; alu_op_o, is_shift_o, is_jr_o, illegal_o out.
module mc_funct_decode
  import mc_control_pkg::*;
(
  input  logic [5:0] funct_i,
  output alu_op_t    alu_op_o,
  output logic       is_shift_o,
  output logic       is_jr_o,
  output logic       illegal_o
);
  always_comb begin
    alu_op_o   = OP_ADD;
    is_shift_o = 1'b0;
    is_jr_o    = 1'b0;
    illegal_o  = 1'b0;
    unique case (funct_i)
      FN_ADD: alu_op_o = OP_ADD;
      FN_SUB: alu_op_o = OP_SUB;
      FN_AND: alu_op_o = OP_AND;
      FN_OR:  alu_op_o = OP_OR;
      FN_XOR: alu_op_o = OP_XOR;
      FN_NOR: alu_op_o = OP_NOR;
      FN_SLT: alu_op_o = OP_SLT;
      FN_SLL: begin
        alu_op_o   = OP_SLL;
        is_shift_o = 1'b1;
      end
      FN_SRL: begin
        alu_op_o   = OP_SRL;
        is_shift_o = 1'b1;
      end
      FN_SRA: begin
        alu_op_o   = OP_SRA;
        is_shift_o = 1'b1;
      end
      FN_JR:   is_jr_o   = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/mc_control_p.sv
// mc_control_p: multicycle MIPS control FSM; clk, rstb (async low), bus (master).
// MC_CONTROL_MEM_HANDSHAKE_EN: memory states complete on mem_ready, no counter.
module mc_control_p
  import mc_control_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ALU_CTRL_W  = 4,
  parameter int STATE_W     = 5
) (
  input  logic         clk,
  input  logic         rstb,
  mc_control_if.master bus
);
  state_e  state_q, state_d;
  ctrl_t   c, o;
  logic    mem_done;
  logic    in_mem;
  alu_op_t fn_alu;
  logic    fn_shift, fn_jr, fn_bad;
  logic    op_r, op_mem, op_br, op_j, op_jal;
  logic    op_i, i_zext;
  alu_op_t i_alu;

  mc_funct_decode u_fdec (
    .funct_i   (bus.funct),
    .alu_op_o  (fn_alu),
    .is_shift_o(fn_shift),
    .is_jr_o   (fn_jr),
    .illegal_o (fn_bad)
  );

  assign op_r   = (bus.op == OPC_RTYPE);
  assign op_mem = (bus.op == OPC_LW) ||
                  (bus.op == OPC_SW);
  assign op_br  = (bus.op == OPC_BEQ) ||
                  (bus.op == OPC_BNE);
  assign op_j   = (bus.op == OPC_J);
  assign op_jal = (bus.op == OPC_JAL);

  always_comb begin
    i_alu  = OP_ADD;
    i_zext = 1'b0;
    op_i   = 1'b1;
    case (bus.op)
      OPC_ADDI: i_alu = OP_ADD;
      OPC_SLTI: i_alu = OP_SLT;
      OPC_ANDI: begin
        i_alu  = OP_AND;
        i_zext = 1'b1;
      end
      OPC_ORI: begin
        i_alu  = OP_OR;
        i_zext = 1'b1;
      end
      OPC_XORI: begin
        i_alu  = OP_XOR;
        i_zext = 1'b1;
      end
      default: op_i = 1'b0;
    endcase
  end

  assign in_mem = (state_q == S_FETCH)  ||
                  (state_q == S_MEM_RD) ||
                  (state_q == S_MEM_WR);

`ifdef MC_CONTROL_MEM_HANDSHAKE_EN
  localparam int unused_lat = MEM_LATENCY;
  logic unused_in_mem;
  assign unused_in_mem = in_mem;
  assign mem_done      = bus.mem_ready;
`else
  localparam int LAT  = (MEM_LATENCY < 1) ? 1 : MEM_LATENCY;
  localparam int CW   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          unused_mem_ready;

  assign unused_mem_ready = bus.mem_ready;
  assign mem_done         = (cnt_q == CMAX);

  // Outside memory states the count is zero, so every access starts fresh.
  always_comb begin
    cnt_d = '0;
    if (in_mem && !mem_done)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    c       = '0;
    unique case (state_q)
      S_FETCH: begin
        c.mem_req = 1'b1;
        if (mem_done) begin
          c.ir_write    = 1'b1;
          c.pc_write    = 1'b1;
          c.alu_src_a   = SRCA_PC;
          c.alu_src_b   = SRCB_FOUR;
          c.alu_control = OP_ADD;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_a   = SRCA_PC;
        c.alu_src_b   = SRCB_IMM_SH;
        c.alu_control = OP_ADD;
        unique case (1'b1)
          op_mem:                    state_d = S_MEM_ADR;
          (op_r && fn_jr):           state_d = S_JR;
          (op_r && !fn_jr && !fn_bad): state_d = S_R_EXEC;
          op_i:                      state_d = S_I_EXEC;
          op_br:                     state_d = S_BRANCH;
          op_j:                      state_d = S_JUMP;
          op_jal:                    state_d = S_JAL;
          default: begin
            c.illegal_op = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADR: begin
        c.alu_src_a   = SRCA_REG;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = OP_ADD;
        state_d = (bus.op == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
        if (mem_done) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RT;
        c.mem_to_reg = M2R_MDR;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        c.mem_req   = 1'b1;
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
        if (mem_done) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        c.alu_src_a   = fn_shift ? SRCA_SHAMT : SRCA_REG;
        c.alu_src_b   = SRCB_REG;
        c.alu_control = fn_alu;
        state_d       = S_R_WB;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = DST_RD;
        state_d     = S_FETCH;
      end
      S_I_EXEC: begin
        c.alu_src_a   = SRCA_REG;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = i_alu;
        c.imm_zext    = i_zext;
        state_d       = S_I_WB;
      end
      S_I_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RT;
        c.mem_to_reg = M2R_ALUOUT;
        c.imm_zext   = i_zext;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a   = SRCA_REG;
        c.alu_src_b   = SRCB_REG;
        c.alu_control = OP_SUB;
        c.branch      = 1'b1;
        c.branch_ne   = (bus.op == OPC_BNE);
        c.pc_src      = PCS_ALUOUT;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCS_JUMP;
        state_d    = S_FETCH;
      end
      // PC already holds PC+4 from FETCH, so $31 gets the link value here.
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_src     = PCS_JUMP;
        c.reg_write  = 1'b1;
        c.reg_dst    = DST_RA;
        c.mem_to_reg = M2R_PC;
        state_d      = S_FETCH;
      end
      S_JR: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCS_REG;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset low silences every output, including FETCH's mem_req.
  assign o = rstb ? c : '0;

  assign bus.alu_control = ALU_CTRL_W'(o.alu_control);
  assign bus.alu_src_a   = o.alu_src_a;
  assign bus.alu_src_b   = o.alu_src_b;
  assign bus.pc_src      = o.pc_src;
  assign bus.reg_dst     = o.reg_dst;
  assign bus.mem_to_reg  = o.mem_to_reg;
  assign bus.pc_write    = o.pc_write;
  assign bus.branch      = o.branch;
  assign bus.branch_ne   = o.branch_ne;
  assign bus.reg_write   = o.reg_write;
  assign bus.i_or_d      = o.i_or_d;
  assign bus.mem_req     = o.mem_req;
  assign bus.mem_write   = o.mem_write;
  assign bus.ir_write    = o.ir_write;
  assign bus.imm_zext    = o.imm_zext;
  assign bus.illegal_op  = o.illegal_op;
  assign bus.state_o     = rstb ? STATE_W'(state_q) : '0;
endmodule

// File: tb/tb_mc_control_p.sv
// tb_mc_control_p: random instruction stream vs per-cycle reference plan.
// Scoreboard queue filled by the driver, drained by a negedge monitor.
module tb_mc_control_p;
  import mc_control_pkg::*;

  localparam int LAT = 2;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  mc_control_if #(.ALU_CTRL_W(4), .STATE_W(5)) bus ();

  mc_control_p #(
    .MEM_LATENCY(LAT),
    .ALU_CTRL_W (4),
    .STATE_W    (5)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sa;
    logic [2:0] sb;
    logic [1:0] pcs;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic pcw, br, bne, rw, iord;
    logic mreq, mwr, irw, zext, ill;
  } out_t;

  typedef struct {
    out_t       o;
    logic       rdy;
    logic [5:0] op;
    logic [5:0] fn;
    int         idx;
  } exp_t;

  exp_t plan[$];
  exp_t sb[$];
  exp_t me;

  int   rmap[int];
  bit   rshift[int];
  int   imap[int];
  bit   izext[int];

  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   force_wait = -1;
  logic [5:0] cur_op, cur_fn;

  function automatic out_t act();
    out_t a;
    a.alu  = bus.alu_control;
    a.sa   = bus.alu_src_a;
    a.sb   = bus.alu_src_b;
    a.pcs  = bus.pc_src;
    a.rd   = bus.reg_dst;
    a.m2r  = bus.mem_to_reg;
    a.pcw  = bus.pc_write;
    a.br   = bus.branch;
    a.bne  = bus.branch_ne;
    a.rw   = bus.reg_write;
    a.iord = bus.i_or_d;
    a.mreq = bus.mem_req;
    a.mwr  = bus.mem_write;
    a.irw  = bus.ir_write;
    a.zext = bus.imm_zext;
    a.ill  = bus.illegal_op;
    return a;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string nm, input out_t got, input out_t want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic add(input out_t o, input logic rdy);
    exp_t e;
    e.o   = o;
    e.rdy = rdy;
    e.op  = cur_op;
    e.fn  = cur_fn;
    e.idx = plan.size();
    plan.push_back(e);
  endtask

  task automatic add_mem(input out_t hold, input out_t last);
    int n;
`ifdef MC_CONTROL_MEM_HANDSHAKE_EN
    n = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
    force_wait = -1;
    repeat (n) add(hold, 1'b0);
    add(last, 1'b1);
`else
    n = LAT - 1;
    repeat (n) add(hold, rnd());
    add(last, rnd());
`endif
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    out_t h, o;
    bit   legal;
    int   k;
    plan.delete();
    cur_op = op;
    cur_fn = fn;
    k = int'(op);
    h = '0; h.mreq = 1;
    o = h; o.irw = 1; o.pcw = 1; o.sb = 3'd1; o.alu = OP_ADD;
    add_mem(h, o);
    if (op == 6'h00)
      legal = rmap.exists(int'(fn)) || (fn == 6'd8);
    else
      legal = (op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B}) ||
              imap.exists(k);
    o = '0; o.sb = 3'd3; o.alu = OP_ADD; o.ill = !legal;
    add(o, rnd());
    if (!legal) return;
    if (op == 6'h23 || op == 6'h2B) begin
      o = '0; o.sa = 2'd1; o.sb = 3'd2; o.alu = OP_ADD;
      add(o, rnd());
      h = '0; h.mreq = 1; h.iord = 1; h.mwr = (op == 6'h2B);
      add_mem(h, h);
      if (op == 6'h23) begin
        o = '0; o.rw = 1; o.m2r = 2'd1;
        add(o, rnd());
      end
    end else if (op == 6'h00 && fn == 6'd8) begin
      o = '0; o.pcw = 1; o.pcs = 2'd3;
      add(o, rnd());
    end else if (op == 6'h00) begin
      o = '0; o.alu = 4'(rmap[int'(fn)]);
      o.sa = rshift.exists(int'(fn)) ? 2'd2 : 2'd1;
      add(o, rnd());
      o = '0; o.rw = 1; o.rd = 2'd1;
      add(o, rnd());
    end else if (imap.exists(k)) begin
      o = '0; o.sa = 2'd1; o.sb = 3'd2;
      o.alu = 4'(imap[k]); o.zext = izext.exists(k);
      add(o, rnd());
      o = '0; o.rw = 1; o.zext = izext.exists(k);
      add(o, rnd());
    end else if (op == 6'h04 || op == 6'h05) begin
      o = '0; o.sa = 2'd1; o.alu = OP_SUB; o.br = 1;
      o.pcs = 2'd1; o.bne = (op == 6'h05);
      add(o, rnd());
    end else if (op == 6'h02) begin
      o = '0; o.pcw = 1; o.pcs = 2'd2;
      add(o, rnd());
    end else begin
      o = '0; o.pcw = 1; o.pcs = 2'd2; o.rw = 1;
      o.rd = 2'd2; o.m2r = 2'd2;
      add(o, rnd());
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn);
    build(op, fn);
    foreach (plan[i]) begin
      bus.op        = op;
      bus.funct     = fn;
      bus.mem_ready = plan[i].rdy;
      sb.push_back(plan[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard empty at %0t", $time);
      end else begin
        me = sb.pop_front();
        n_vec++;
        if (act() !== me.o) begin
          n_err++;
          $display("FAIL op=%h funct=%h cyc=%0d: got %h expected %h",
                   me.op, me.fn, me.idx, act(), me.o);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int   fns[11] = '{32, 34, 36, 37, 38, 39, 42, 0, 2, 3, 8};
  int   ops[14] = '{0, 0, 0, 2, 3, 4, 5, 8, 10, 12, 13, 14, 35, 43};
  int   nf;
  int   sel;
  logic [5:0] rop, rfn;
  out_t w;

  initial begin
    rmap[32] = OP_ADD; rmap[34] = OP_SUB; rmap[36] = OP_AND;
    rmap[37] = OP_OR;  rmap[38] = OP_XOR; rmap[39] = OP_NOR;
    rmap[42] = OP_SLT; rmap[0]  = OP_SLL; rmap[2]  = OP_SRL;
    rmap[3]  = OP_SRA;
    rshift[0] = 1; rshift[2] = 1; rshift[3] = 1;
    imap[8]  = OP_ADD; imap[10] = OP_SLT; imap[12] = OP_AND;
    imap[13] = OP_OR;  imap[14] = OP_XOR;
    izext[12] = 1; izext[13] = 1; izext[14] = 1;

    bus.op = 6'h23; bus.funct = 6'h20; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", act(), '0);
    n_vec++;
    if (bus.state_o !== 5'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected 0", bus.state_o);
    end

    @(posedge clk); #1;
    rstb   = 1'b1;
    mon_en = 1'b1;
`ifdef MC_CONTROL_MEM_HANDSHAKE_EN
    force_wait = 10;
`endif
    run(6'h00, 6'd32);
    run(6'h23, 6'd0);
    run(6'h2B, 6'd0);
    run(6'h05, 6'd0);
    run(6'h04, 6'd0);
    run(6'h03, 6'd0);
    run(6'h00, 6'd8);
    run(6'h00, 6'd0);
    run(6'h3F, 6'd0);
    run(6'h00, 6'h3F);
    run(6'h0C, 6'd0);
    run(6'h0D, 6'd0);
    run(6'h02, 6'd0);
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 17);
      rop = (sel < 14) ? 6'(ops[sel]) : 6'($urandom);
      if ($urandom_range(0, 4) == 0) rfn = 6'($urandom);
      else rfn = 6'(fns[$urandom_range(0, 10)]);
      run(rop, rfn);
    end
    mon_en = 1'b0;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

`ifdef MC_CONTROL_MEM_HANDSHAKE_EN
    nf = 1;
`else
    nf = LAT;
`endif
    bus.op = 6'h23; bus.funct = 6'd0; bus.mem_ready = 1'b1;
    repeat (nf) step();
    bus.mem_ready = 1'b0;
    repeat (2) step();
    w = '0; w.mreq = 1; w.iord = 1;
    check("mid_mem_rd", act(), w);
    #2 rstb = 1'b0;
    #1 check("reset_mid_hold", act(), '0);
    n_vec++;
    if (bus.state_o !== 5'd0) begin
      n_err++;
      $display("FAIL reset_mid_state: got %0d expected 0", bus.state_o);
    end
    step();
    rstb = 1'b1;
    #1;
    w = '0; w.mreq = 1;
    check("post_reset_fetch", act(), w);
`ifndef MC_CONTROL_MEM_HANDSHAKE_EN
    step();
`endif
    bus.mem_ready = 1'b1;
    #1;
    w.irw = 1; w.pcw = 1; w.sb = 3'd1;
    check("post_reset_strobe", act(), w);
    step();
    w = '0; w.sb = 3'd3;
    check("post_reset_decode", act(), w);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
